// File: rtl/ssd_count_ctrl.sv
// Start/pause/clear/load sequencer producing the 4-bit count shown on the HEX decoders.
// Steps 0..MAX_STATE up or down every DIV clocks, with wrap-around.
module ssd_count_ctrl #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned MAX_STATE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       up_dn,
  output logic [3:0] cnt,
  output logic       step,
  output logic       wrap,
  output logic       running
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);
  localparam logic [3:0]    CNT_MAX  = 4'(MAX_STATE);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;

  logic          key_s1, key_s2, key_s3;
  logic [1:0]    vld;
  logic          armed;
  logic          press_p;

  logic [1:0]    fsm, fsm_d;
  logic [PW-1:0] psc, psc_d;
  logic [3:0]    cnt_d;
  logic          step_d, wrap_d, running_d;

  // Button synchroniser; armed blocks a press that was already held across reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_s3 <= 1'b1;
      vld    <= 2'b00;
      armed  <= 1'b0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      vld    <= {vld[0], 1'b1};
      armed  <= armed | (vld[1] & key_s2);
    end
  end

  assign press_p = armed & key_s3 & ~key_s2;

  // Next-state: clr > load (outside RUN) > stepping/press handling.
  always_comb begin
    fsm_d  = fsm;
    psc_d  = psc;
    cnt_d  = cnt;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (clr) begin
      fsm_d = IDLE;
      cnt_d = 4'd0;
      psc_d = '0;
    end else if (load && (fsm != RUN)) begin
      cnt_d = (load_val > CNT_MAX) ? CNT_MAX : load_val;
      psc_d = '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (press_p) begin
            fsm_d = RUN;
            psc_d = '0;
          end
        end
        RUN: begin
          if (psc == PSC_LAST) begin
            psc_d  = '0;
            step_d = 1'b1;
            if (up_dn) begin
              wrap_d = (cnt == CNT_MAX);
              cnt_d  = (cnt == CNT_MAX) ? 4'd0 : cnt + 4'd1;
            end else begin
              wrap_d = (cnt == 4'd0);
              cnt_d  = (cnt == 4'd0) ? CNT_MAX : cnt - 4'd1;
            end
          end else if (!press_p) begin
            psc_d = psc + PW'(1);
          end
          if (press_p) fsm_d = PAUSED;
        end
        PAUSED: begin
          if (press_p) fsm_d = RUN;
        end
        default: fsm_d = IDLE;
      endcase
    end
    running_d = (fsm_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      psc     <= '0;
      cnt     <= 4'd0;
      step    <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      fsm     <= fsm_d;
      psc     <= psc_d;
      cnt     <= cnt_d;
      step    <= step_d;
      wrap    <= wrap_d;
      running <= running_d;
    end
  end

endmodule

// File: tb/tb_ssd_count_ctrl.sv
// Directed bench for ssd_count_ctrl with DIV = 4, MAX_STATE = 10.
module tb_ssd_count_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       up_dn;
  logic [3:0] cnt;
  logic       step;
  logic       wrap;
  logic       running;

  int tests = 0;
  int fails = 0;

  ssd_count_ctrl #(.DIV(4), .MAX_STATE(10)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .clr(clr), .load(load),
    .load_val(load_val), .up_dn(up_dn), .cnt(cnt), .step(step),
    .wrap(wrap), .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_n = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0; up_dn = 1'b1;
    repeat (2) tick();
    tests++;
    if ({cnt, step, wrap, running} !== 7'b0) begin
      fails++;
      $display("FAIL reset: got cnt=%0d step=%b wrap=%b running=%b, want all 0", cnt, step, wrap, running);
    end
    #3 rst_n = 1'b1;
    repeat (3) tick();
    tests++;
    if ({cnt, step, running} !== 6'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got cnt=%0d step=%b running=%b, want 0", cnt, step, running);
    end
  endtask

  task automatic test_up_count();
    logic [3:0] exp_cnt;
    logic [3:0] prev_cnt;
    key_n = 1'b0;
    tick(); tick();
    tests++;
    if (running !== 1'b0) begin
      fails++; $display("FAIL press_edge2: running=%b want 0", running);
    end
    tick();
    tests++;
    if (running !== 1'b1 || cnt !== 4'd0) begin
      fails++; $display("FAIL press_edge3: running=%b cnt=%0d want 1/0", running, cnt);
    end
    for (int i = 1; i <= 11; i++) begin
      exp_cnt  = 4'(i % 11);
      prev_cnt = 4'((i - 1) % 11);
      for (int j = 1; j <= 4; j++) begin
        tick();
        if (i == 1 && j == 2) key_n = 1'b1;
        tests++;
        if (j < 4) begin
          if (step !== 1'b0 || wrap !== 1'b0 || cnt !== prev_cnt) begin
            fails++;
            $display("FAIL up_hold i=%0d j=%0d: step=%b wrap=%b cnt=%0d want 0/0/%0d", i, j, step, wrap, cnt, prev_cnt);
          end
        end else begin
          if (step !== 1'b1 || cnt !== exp_cnt || wrap !== (i == 11)) begin
            fails++;
            $display("FAIL up_step i=%0d: step=%b cnt=%0d wrap=%b want 1/%0d/%b", i, step, cnt, wrap, exp_cnt, (i == 11));
          end
        end
      end
    end
  endtask

  task automatic test_down_wrap();
    up_dn = 1'b0;
    repeat (4) tick();
    tests++;
    if (step !== 1'b1 || cnt !== 4'd10 || wrap !== 1'b1) begin
      fails++; $display("FAIL down_wrap: step=%b cnt=%0d wrap=%b want 1/10/1", step, cnt, wrap);
    end
    repeat (4) tick();
    tests++;
    if (step !== 1'b1 || cnt !== 4'd9 || wrap !== 1'b0) begin
      fails++; $display("FAIL down_next: step=%b cnt=%0d wrap=%b want 1/9/0", step, cnt, wrap);
    end
  endtask

  task automatic test_pause_resume();
    key_n = 1'b0;
    tick(); tick();
    tests++;
    if (running !== 1'b1) begin
      fails++; $display("FAIL pause_pre: running=%b want 1", running);
    end
    tick();
    tests++;
    if (running !== 1'b0 || cnt !== 4'd9 || step !== 1'b0) begin
      fails++; $display("FAIL pause_enter: running=%b cnt=%0d step=%b want 0/9/0", running, cnt, step);
    end
    key_n = 1'b1;
    repeat (6) tick();
    tests++;
    if (running !== 1'b0 || cnt !== 4'd9 || step !== 1'b0) begin
      fails++; $display("FAIL pause_frozen: running=%b cnt=%0d step=%b want 0/9/0", running, cnt, step);
    end
    up_dn = 1'b1;
    key_n = 1'b0;
    repeat (3) tick();
    tests++;
    if (running !== 1'b1 || cnt !== 4'd9) begin
      fails++; $display("FAIL resume: running=%b cnt=%0d want 1/9", running, cnt);
    end
    key_n = 1'b1;
    tick();
    tests++;
    if (step !== 1'b0) begin
      fails++; $display("FAIL resume_plus1: step=%b want 0", step);
    end
    tick();
    tests++;
    if (step !== 1'b1 || cnt !== 4'd10 || wrap !== 1'b0) begin
      fails++; $display("FAIL resume_plus2: step=%b cnt=%0d wrap=%b want 1/10/0", step, cnt, wrap);
    end
  endtask

  task automatic test_press_on_step();
    tick();
    key_n = 1'b0;
    repeat (3) tick();
    tests++;
    if (step !== 1'b1 || cnt !== 4'd0 || wrap !== 1'b1 || running !== 1'b0) begin
      fails++;
      $display("FAIL press_on_step: step=%b cnt=%0d wrap=%b running=%b want 1/0/1/0", step, cnt, wrap, running);
    end
    key_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++;
      if (step !== 1'b0 || cnt !== 4'd0 || running !== 1'b0) begin
        fails++;
        $display("FAIL after_press_step k=%0d: step=%b cnt=%0d running=%b want 0/0/0", k, step, cnt, running);
      end
    end
  endtask

  task automatic test_load_clr();
    load_val = 4'd13; load = 1'b1;
    tick();
    load = 1'b0;
    tests++;
    if (cnt !== 4'd10 || running !== 1'b0) begin
      fails++; $display("FAIL load_clamp: cnt=%0d running=%b want 10/0", cnt, running);
    end
    key_n = 1'b0;
    repeat (3) tick();
    tests++;
    if (running !== 1'b1) begin
      fails++; $display("FAIL load_resume: running=%b want 1", running);
    end
    key_n = 1'b1;
    load_val = 4'd3; load = 1'b1;
    tick();
    load = 1'b0;
    tests++;
    if (cnt !== 4'd10 || running !== 1'b1) begin
      fails++; $display("FAIL load_in_run: cnt=%0d running=%b want 10/1", cnt, running);
    end
    clr = 1'b1; load = 1'b1;
    tick();
    clr = 1'b0; load = 1'b0;
    tests++;
    if (cnt !== 4'd0 || running !== 1'b0 || step !== 1'b0) begin
      fails++; $display("FAIL clr_load: cnt=%0d running=%b step=%b want 0/0/0", cnt, running, step);
    end
    repeat (5) tick();
    tests++;
    if (cnt !== 4'd0 || step !== 1'b0 || running !== 1'b0) begin
      fails++; $display("FAIL idle_hold: cnt=%0d step=%b running=%b want 0/0/0", cnt, step, running);
    end
    load_val = 4'd5; load = 1'b1;
    tick();
    load = 1'b0;
    tests++;
    if (cnt !== 4'd5 || running !== 1'b0) begin
      fails++; $display("FAIL load_idle: cnt=%0d running=%b want 5/0", cnt, running);
    end
  endtask

  task automatic test_async_reset();
    key_n = 1'b0;
    repeat (3) tick();
    tests++;
    if (running !== 1'b1) begin
      fails++; $display("FAIL start_from_idle: running=%b want 1", running);
    end
    repeat (4) tick();
    tests++;
    if (step !== 1'b1 || cnt !== 4'd6) begin
      fails++; $display("FAIL step_before_rst: step=%b cnt=%0d want 1/6", step, cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({cnt, step, wrap, running} !== 7'b0) begin
      fails++;
      $display("FAIL async_rst: cnt=%0d step=%b wrap=%b running=%b want all 0", cnt, step, wrap, running);
    end
    #2 rst_n = 1'b1;
    repeat (8) tick();
    tests++;
    if (running !== 1'b0 || step !== 1'b0) begin
      fails++; $display("FAIL held_key_after_rst: running=%b step=%b want 0/0", running, step);
    end
    key_n = 1'b1;
    repeat (4) tick();
    key_n = 1'b0;
    repeat (3) tick();
    tests++;
    if (running !== 1'b1) begin
      fails++; $display("FAIL press_after_rst: running=%b want 1", running);
    end
    key_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_pause_resume();
    test_press_on_step();
    test_load_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
